// File: rtl/ws_inst_sequencer.sv
// ============================================================================
// ws_inst_sequencer
// ----------------------------------------------------------------------------
// Instruction sequencer for the weight-stationary core. One start pulse runs
// every kernel position (kij). Each kij does the following in order:
//   - read col weight rows from XMEM into L0 (load),
//   - read len_nij activation rows (execute),
//   - issue one flush cycle (load+execute+mode),
//   - wait gap idle cycles.
// A separate writeback engine drains OFIFO into PMEM while the run is busy.
// It writes one PMEM row per valid psum, at sequential addresses.
//
// Ports
//   i_clk          clock, rising edge
//   i_reset        asynchronous reset, active low (0 = reset)
//   i_start        one-cycle pulse, begins a run when idle
//   i_l0_ready     L0 can accept a row this cycle
//   i_ofifo_valid  OFIFO holds a psum row
//   o_inst[39:0]   core instruction bus (registered)
//   o_busy         run in progress
//   o_done         one-cycle pulse when the run completes
//   o_kij_idx      kernel position currently being issued
// ============================================================================
module ws_inst_sequencer #(
    parameter int          COL     = 8,
    parameter int          LEN_KIJ = 9,
    parameter int          LEN_NIJ = 36,
    parameter logic [7:0]  W_BASE  = 8'h80,
    parameter logic [7:0]  X_BASE  = 8'h00,
    parameter int          GAP     = 19
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_l0_ready,
    input  logic        i_ofifo_valid,
    output logic [39:0] o_inst,
    output logic        o_busy,
    output logic        o_done,
    output logic [3:0]  o_kij_idx
);

    localparam int WB_TOTAL = LEN_KIJ * LEN_NIJ;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADW,
        S_EXEC,
        S_FLUSH,
        S_GAP,
        S_WAITD
    } state_t;

    // ------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [6:0]  r_t;          // rows still to issue in the current burst
    logic [3:0]  r_kij;
    logic [5:0]  r_gap;        // idle cycles remaining after a flush
    logic        r_busy;
    logic        r_bypass;
    logic        r_done;
    logic [9:0]  r_wb_cnt;     // PMEM rows written in this run
    logic [2:0]  r_ctl_d1;     // {mode, execute, load} delay line
    logic [2:0]  r_ctl_d2;
    logic [39:0] r_inst;

    state_t      w_state_next;
    logic [6:0]  w_t_next;
    logic [3:0]  w_kij_next;
    logic [5:0]  w_gap_next;
    logic        w_busy_next;
    logic        w_bypass_next;
    logic        w_done_next;
    logic        w_wb_clear;
    logic        w_cen0;
    logic [7:0]  w_a0;
    logic [2:0]  w_ctl;        // {mode, execute, load} decided this cycle
    logic        w_wr;
    logic [39:0] w_inst_next;

    // ------------------------------------------------------------------
    // Issue FSM: next state and per-cycle decision
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_t_next      = r_t;
        w_kij_next    = r_kij;
        w_gap_next    = r_gap;
        w_busy_next   = r_busy;
        w_bypass_next = r_bypass;
        w_done_next   = 1'b0;
        w_wb_clear    = 1'b0;
        w_cen0        = 1'b1;
        w_a0          = 8'h00;
        w_ctl         = 3'b000;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next  = S_LOADW;
                    w_busy_next   = 1'b1;
                    w_bypass_next = 1'b1;
                    w_kij_next    = 4'd0;
                    w_t_next      = 7'(COL);
                    w_wb_clear    = 1'b1;
                end
            end

            S_LOADW: begin
                // The row offset (col - t) only advances on cycles L0 accepts.
                // A stall therefore never skips or repeats an address.
                if (i_l0_ready) begin
                    w_cen0   = 1'b0;
                    w_a0     = W_BASE + (8'(r_kij) * 8'(COL)) + (8'(COL) - 8'(r_t));
                    w_ctl    = 3'b001;
                    w_t_next = r_t - 7'd1;
                    if (r_t == 7'd1) begin
                        w_state_next = S_EXEC;
                        w_t_next     = 7'(LEN_NIJ);
                    end
                end
            end

            S_EXEC: begin
                if (i_l0_ready) begin
                    w_cen0   = 1'b0;
                    w_a0     = X_BASE + (8'(LEN_NIJ) - 8'(r_t));
                    w_ctl    = 3'b010;
                    w_t_next = r_t - 7'd1;
                    if (r_t == 7'd1) begin
                        w_state_next = S_FLUSH;
                    end
                end
            end

            S_FLUSH: begin
                w_ctl        = 3'b111;
                w_state_next = S_GAP;
                w_gap_next   = 6'(GAP);
            end

            S_GAP: begin
                w_gap_next = r_gap - 6'd1;
                if (r_gap == 6'd1) begin
                    if (r_kij < 4'(LEN_KIJ - 1)) begin
                        w_kij_next   = r_kij + 4'd1;
                        w_t_next     = 7'(COL);
                        w_state_next = S_LOADW;
                    end else begin
                        w_state_next = S_WAITD;
                    end
                end
            end

            S_WAITD: begin
                if (r_wb_cnt == 10'(WB_TOTAL)) begin
                    w_done_next   = 1'b1;
                    w_busy_next   = 1'b0;
                    w_bypass_next = 1'b0;
                    w_state_next  = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Writeback engine: works independently of the issue FSM. Once the
    // run's full psum count is written, further valids are dropped.
    // ------------------------------------------------------------------
    assign w_wr = r_busy && i_ofifo_valid && (r_wb_cnt < 10'(WB_TOTAL));

    // ------------------------------------------------------------------
    // Instruction word assembly. The load/execute/mode bits come from the
    // end of the delay line, so they reach L0 with the XMEM read data.
    // ------------------------------------------------------------------
    always_comb begin
        w_inst_next        = 40'd0;
        w_inst_next[39]    = w_bypass_next;     // psum_bypass
        w_inst_next[38]    = 1'b0;              // acc
        w_inst_next[37]    = ~w_wr;             // CEN_pmem
        w_inst_next[36]    = ~w_wr;             // WEN_pmem
        w_inst_next[35:27] = r_wb_cnt[8:0];     // A_pmem
        w_inst_next[26]    = 1'b1;              // CEN1_xmem
        w_inst_next[25:18] = 8'h00;             // A1_xmem
        w_inst_next[17]    = w_cen0;            // CEN0_xmem
        w_inst_next[16]    = 1'b1;              // WEN0_xmem: XMEM is read-only here
        w_inst_next[15:8]  = w_a0;              // A0_xmem
        w_inst_next[7]     = w_wr;              // ofifo_rd
        w_inst_next[6:3]   = 4'h0;              // ififo_wr, ififo_rd, l0_rd, l0_wr
        w_inst_next[2:0]   = r_ctl_d2;          // mode, execute, load
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state  <= S_IDLE;
            r_t      <= 7'd0;
            r_kij    <= 4'd0;
            r_gap    <= 6'd0;
            r_busy   <= 1'b0;
            r_bypass <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_t      <= w_t_next;
            r_kij    <= w_kij_next;
            r_gap    <= w_gap_next;
            r_busy   <= w_busy_next;
            r_bypass <= w_bypass_next;
            r_done   <= w_done_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wb_cnt <= 10'd0;
        end else if (w_wb_clear) begin
            r_wb_cnt <= 10'd0;
        end else if (w_wr) begin
            r_wb_cnt <= r_wb_cnt + 10'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_ctl_d1 <= 3'b000;
            r_ctl_d2 <= 3'b000;
        end else begin
            r_ctl_d1 <= w_ctl;
            r_ctl_d2 <= r_ctl_d1;
        end
    end

    // Idle encoding: every XMEM/PMEM enable and write-enable is deasserted (high).
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_inst     <= 40'd0;
            r_inst[37] <= 1'b1;
            r_inst[36] <= 1'b1;
            r_inst[26] <= 1'b1;
            r_inst[17] <= 1'b1;
            r_inst[16] <= 1'b1;
        end else begin
            r_inst <= w_inst_next;
        end
    end

    assign o_inst    = r_inst;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_kij_idx = r_kij;

endmodule

// File: tb/tb_ws_inst_sequencer.sv
// ============================================================================
// tb_ws_inst_sequencer
// Random stimulus for l0_ready and ofifo_valid. A reference model checks every
// cycle. The model tracks the run as counts, not as FSM states:
//   - position in the list of 9*(8+36) XMEM reads,
//   - number of PMEM writes so far,
//   - the earliest cycle at which the next read may appear.
// Directed segments cover these cases: a stall at A0=0x10, writes beyond the
// run total, start while busy, start during reset, and reset mid-run.
// ============================================================================
module tb_ws_inst_sequencer;

    localparam int COL         = 8;
    localparam int PER_KIJ     = 44;
    localparam int TOTAL_READS = 396;
    localparam int TOTAL_WR    = 324;
    localparam int GAP         = 19;
    localparam int RUN_LIMIT   = 3000;
    localparam logic [39:0] RST_INST = 40'h30_0403_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        l0_ready;
    logic        ofifo_valid;
    logic [39:0] inst;
    logic        busy;
    logic        done;
    logic [3:0]  kij_idx;

    always #5 clk = ~clk;

    ws_inst_sequencer dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_start       (start),
        .i_l0_ready    (l0_ready),
        .i_ofifo_valid (ofifo_valid),
        .o_inst        (inst),
        .o_busy        (busy),
        .o_done        (done),
        .o_kij_idx     (kij_idx)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    // reference model
    bit m_busy;
    int m_reads, m_wb, m_earliest, m_waitd_edge;
    logic [2:0] ctl_at [int];

    // observations for run-level checks and stimulus reactions
    int obs_done, obs_wr;
    bit last_rd;
    int last_pos, last_addr;
    int v_burst, v_idle;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp_v, edge_n);
        end
    endtask

    task automatic chk_reset(input string tag);
        check_eq({tag, "_inst"}, 64'(inst), 64'(RST_INST));
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_done"}, 64'(done), 64'd0);
        check_eq({tag, "_kij"},  64'(kij_idx), 64'd0);
    endtask

    task automatic model_clear();
        m_busy       = 1'b0;
        m_reads      = 0;
        m_wb         = 0;
        m_earliest   = 0;
        m_waitd_edge = 0;
        ctl_at.delete();
    endtask

    // Advance one clock. Compare the DUT outputs against the model.
    task automatic tick();
        bit r, v, s, busy_prev, exp_read, exp_wr, exp_done;
        logic [2:0] exp_ctl;
        int kij, pos, addr;
        r = l0_ready;
        v = ofifo_valid;
        s = start;
        @(posedge clk);
        #1;
        edge_n++;
        busy_prev = m_busy;
        exp_done  = busy_prev && (m_reads == TOTAL_READS) && (edge_n >= m_waitd_edge + 1)
                    && (m_wb == TOTAL_WR);
        exp_read  = busy_prev && (m_reads < TOTAL_READS) && (edge_n >= m_earliest) && r;
        exp_wr    = busy_prev && v && (m_wb < TOTAL_WR);
        exp_ctl   = 3'b000;
        if (ctl_at.exists(edge_n)) begin
            exp_ctl = ctl_at[edge_n];
            ctl_at.delete(edge_n);
        end

        check_eq("cen0", 64'(inst[17]), 64'(!exp_read));
        last_rd = exp_read;
        if (exp_read) begin
            kij  = m_reads / PER_KIJ;
            pos  = m_reads % PER_KIJ;
            addr = (pos < COL) ? ('h80 + COL * kij + pos) : (pos - COL);
            last_pos  = pos;
            last_addr = addr;
            check_eq("a0", 64'(inst[15:8]), 64'(addr));
            check_eq("kij_idx", 64'(kij_idx), 64'(kij));
            ctl_at[edge_n + 2] = (pos < COL) ? 3'b001 : 3'b010;
            if (pos == PER_KIJ - 1) begin
                ctl_at[edge_n + 3] = 3'b111;
                m_earliest   = edge_n + GAP + 2;
                m_waitd_edge = edge_n + GAP + 1;
            end
            m_reads++;
        end
        check_eq("ctl", 64'(inst[2:0]), 64'(exp_ctl));

        check_eq("pmem_cen", 64'(inst[37]), 64'(!exp_wr));
        check_eq("pmem_wen", 64'(inst[36]), 64'(!exp_wr));
        check_eq("ofifo_rd", 64'(inst[7]),  64'(exp_wr));
        if (exp_wr) begin
            check_eq("a_pmem", 64'(inst[35:27]), 64'(m_wb));
            m_wb++;
        end

        if (exp_done) m_busy = 1'b0;
        check_eq("done", 64'(done), 64'(exp_done));

        if (!busy_prev && s) begin
            m_busy       = 1'b1;
            m_reads      = 0;
            m_wb         = 0;
            m_earliest   = edge_n + 1;
            m_waitd_edge = 0;
        end
        check_eq("busy", 64'(busy), 64'(m_busy));
        check_eq("bypass", 64'(inst[39]), 64'(m_busy));
        check_eq("const", 64'({inst[38], inst[26], inst[25:18], inst[16], inst[6:3]}),
                 64'({1'b0, 1'b1, 8'h00, 1'b1, 4'h0}));

        obs_done += int'(done);
        obs_wr   += int'(inst[7]);
    endtask

    // vmode 0: always valid, 1: 50% random, 2: bursts of 36 mixed with isolated pulses
    function automatic bit next_valid(input int vmode);
        bit v;
        v = 1'b0;
        if (vmode == 0) begin
            v = 1'b1;
        end else if (vmode == 1) begin
            v = ($urandom_range(0, 1) == 1);
        end else if (v_burst > 0) begin
            v = 1'b1;
            v_burst--;
        end else if (v_idle > 0) begin
            v_idle--;
        end else begin
            v_burst = ($urandom_range(0, 2) == 0) ? 36 : 1;
            v_idle  = $urandom_range(1, 4);
        end
        return v;
    endfunction

    // Start a run, then drive random inputs. Stop at done, at stop_reads
    // issued reads (if nonzero), or at the cycle limit.
    task automatic run_phase(input int rdy_pct, input int vmode, input bit stall_at_10,
                             input int stop_reads, input int start_poke);
        int cyc, stall_left;
        bit stall_done;
        cyc = 0;
        stall_left = 0;
        stall_done = 1'b0;
        obs_done = 0;
        obs_wr = 0;
        v_burst = 0;
        v_idle = 0;
        forever begin
            start = (cyc == 0) || (start_poke > 0 && cyc == start_poke);
            if (stall_left > 0) begin
                l0_ready = 1'b0;
                stall_left--;
            end else begin
                l0_ready = ($urandom_range(0, 99) < rdy_pct);
            end
            ofifo_valid = next_valid(vmode);
            tick();
            cyc++;
            if (stall_at_10 && !stall_done && last_rd && last_pos >= COL && last_addr == 'h10) begin
                stall_left = 5;
                stall_done = 1'b1;
            end
            if (cyc > 1 && !m_busy) break;
            if (stop_reads > 0 && m_reads >= stop_reads) break;
            if (cyc >= RUN_LIMIT) begin
                check_eq("run_timeout", 64'd0, 64'd1);
                break;
            end
        end
        start = 1'b0;
    endtask

    // Idle with valids still asserted: nothing may be written once the run ends.
    task automatic finish_run(input string tag);
        ofifo_valid = 1'b1;
        l0_ready    = 1'b1;
        repeat (5) tick();
        ofifo_valid = 1'b0;
        check_eq({tag, "_done_count"}, 64'(obs_done), 64'd1);
        check_eq({tag, "_wr_count"},   64'(obs_wr), 64'(TOTAL_WR));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        l0_ready = 1'b0;
        ofifo_valid = 1'b0;
        model_clear();
        repeat (10) @(posedge clk);
        #1;
        chk_reset("init");
        rst_n = 1'b1;
        tick();
        tick();

        // Full speed L0, 5-cycle stall at A0=0x10, bursty OFIFO, ignored start mid-run
        run_phase(100, 2, 1'b1, 0, 100);
        finish_run("runA");

        // Slow L0, OFIFO always valid: writes beyond the total while busy are dropped
        run_phase(60, 0, 1'b0, 0, 0);
        finish_run("runB");

        // Reset during kij 4 EXEC
        run_phase(80, 1, 1'b0, 4 * PER_KIJ + COL + 5, 0);
        check_eq("pre_reset_kij", 64'(kij_idx), 64'd4);
        rst_n = 1'b0;
        #1;
        chk_reset("midrun");
        model_clear();
        start = 1'b1;
        @(posedge clk);
        #1;
        chk_reset("start_in_reset");
        start = 1'b0;
        rst_n = 1'b1;
        obs_done = 0;
        repeat (3) tick();
        check_eq("no_partial_done", 64'(obs_done), 64'd0);

        // Restart after reset from A0=0x80, A_pmem=0
        run_phase(75, 2, 1'b0, 0, 50);
        finish_run("runD");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ws_inst_sequencer.md
Name: ws_inst_sequencer

Overview:
- Hardware instruction sequencer for the weight-stationary core.
- Replaces bench-driven stimulus with a synthesizable FSM that drives the core's 40-bit inst bus.
- For each kernel index kij it reads 8 weight rows, then 36 activation rows, from XMEM into L0, and issues the flush/mode pulse.
- In parallel it drains OFIFO into PMEM: one write per valid psum row, at sequential addresses.

Parameters:
- col, 8, array columns = weight rows per kij
- len_kij, 9, kernel positions
- len_nij, 36, activation rows per kij
- w_base, 8'h80, XMEM base address of kij0 weights; kij stride = col
- x_base, 8'h00, XMEM base address of activations
- gap, 19, idle cycles after each flush before the next kij

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- start  in  1  one-cycle pulse; begins a full run when idle
- l0_ready  in  1  L0 can accept a row
- ofifo_valid  in  1  OFIFO holds a psum row
- inst  out  40  core instruction bus:
  - [39] psum_bypass, [38] acc, [37] CEN_pmem, [36] WEN_pmem, [35:27] A_pmem
  - [26] CEN1_xmem, [25:18] A1_xmem, [17] CEN0_xmem, [16] WEN0_xmem, [15:8] A0_xmem
  - [7] ofifo_rd, [6] ififo_wr, [5] ififo_rd, [4] l0_rd, [3] l0_wr, [2] mode, [1] execute, [0] load
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at run completion
- kij_idx  out  4  current kij being issued

Behaviour:
- Reset values:
  - inst: CEN0=1, WEN0=1, CEN1=1, CEN_pmem=1, WEN_pmem=1; all other bits 0.
  - busy=0, done=0, kij_idx=0.
  - All counters and delay-line stages clear.
- Constant fields: acc=0, CEN1=1, A1=0, ififo_wr=0, ififo_rd=0, l0_rd=0, l0_wr=0. WEN0=1 at all times, because this block never writes XMEM.
- Pipeline timing:
  - All inst fields are registered, appearing 1 cycle after the FSM decision.
  - load, execute and mode pass through 2 further register stages, appearing 3 cycles after the decision. This aligns them with XMEM read data reaching L0.
- Issue FSM states:
  - IDLE: start -> LOADW. Set busy=1, psum_bypass=1, kij=0, t=col.
  - LOADW: on each cycle with l0_ready=1, issue CEN0=0 and A0=w_base+kij*col+(col-t); load=1, execute=0, mode=0; t--.
    - l0_ready=0: CEN0=1, counter holds.
    - t reaches 0 -> EXEC with t=len_nij.
  - EXEC: same gating on l0_ready. A0=x_base+(len_nij-t); load=0, execute=1. t reaches 0 -> FLUSH.
  - FLUSH: one cycle with CEN0=1, load=1, execute=1, mode=1 -> GAP.
  - GAP: load=execute=mode=0 for gap cycles. Then, if kij<len_kij-1: kij++, go to LOADW. Otherwise go to WAITD.
  - WAITD: hold until the writeback count reaches len_kij*len_nij. Then pulse done for 1 cycle, clear busy and psum_bypass, and return to IDLE.
- Writeback engine (independent of issue FSM, active while busy):
  - On each cycle with ofifo_valid=1: CEN_pmem=0, WEN_pmem=0, ofifo_rd=1.
  - A_pmem is 0 for the first write and increments by 1 after each write; 9-bit, final value len_kij*len_nij-1 = 323.
  - ofifo_valid=0: CEN_pmem=WEN_pmem=1, ofifo_rd=0.
  - Writes beyond the 324th are ignored (no strobe, no increment).
- Boundary conditions:
  - start while busy: ignored.
  - start coincident with reset: reset wins.
  - Reset mid-run: immediate return to IDLE. Delay line and outputs return to reset values; no partial done.
  - l0_ready dropping mid-burst: issue pauses with no skipped or repeated address.
  - ofifo_valid may be asserted during any issue state, including the GAP of the previous kij.
  - kij_idx is valid in LOADW through GAP and holds in WAITD.

Test Plan:
- Reset: hold reset=0 for 10 cycles -> CEN0=1, WEN0=1, CEN_pmem=1, WEN_pmem=1, load=execute=mode=0, busy=0.
- Weight burst: start with l0_ready=1 -> A0 sequence 0x80..0x87 on consecutive cycles with CEN0=0; load=1 lags each address by exactly 2 cycles; kij=1 begins at 0x88.
- Activation burst: A0 runs 0x00..0x23 (36 reads) with execute=1; then exactly one cycle of load=execute=mode=1, followed by 19 idle cycles.
- Backpressure: l0_ready=0 for 5 cycles mid-EXEC at A0=0x10 -> CEN0=1 during the stall; resumes at 0x11; no duplicate reads.
- Writeback: 324 ofifo_valid cycles, including bursts of 36 and isolated pulses -> A_pmem 0..323, each address exactly once; done pulses once after the last write and after kij 8 finishes; 325th valid is ignored.
- Reset mid-run: reset=0 during kij=4 EXEC -> outputs at reset values within the same cycle; a new start restarts at A0=0x80, A_pmem=0.
